// File: rtl/axi_eth_mac_tx.sv
// Byte-wide Ethernet TX framer: AXI-Stream in, GMII out, with preamble/SFD, CRC-32 FCS and IFG.
// Build option: define AXI_ETH_MAC_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
//
// state      | meaning
// S_IDLE     | waiting for tvalid, line quiet
// S_PREAMBLE | 7x 0x55 then SFD 0xD5; first payload byte taken with the SFD
// S_DATA     | forwarding payload bytes, one cycle behind acceptance
// S_PAD      | zero fill up to MIN_FRAME (pad build only)
// S_FCS      | four inverted CRC bytes, LSB first
// S_DRAIN    | after an underrun: swallow bytes up to tlast, line quiet
// S_IFG      | inter-frame gap, input stalled

module axi_eth_mac_tx #(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_FCS      = 3'd3,
    S_DRAIN    = 3'd4,
    S_IFG      = 3'd5
`ifdef AXI_ETH_MAC_TX_PAD_EN
    , S_PAD    = 3'd6
`endif
  } state_t;

  localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);
`ifdef AXI_ETH_MAC_TX_PAD_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
`endif

  state_t      state;
  logic [7:0]  cnt;
  logic [10:0] byte_cnt;
  logic [10:0] cnt_inc;
  logic [31:0] crc;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32 (poly 0x04C11DB7 reversed), one byte per call.
  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  always_comb begin
    case (cnt[1:0])
      2'd0:    fcs_byte = ~crc[7:0];
      2'd1:    fcs_byte = ~crc[15:8];
      2'd2:    fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  // Ready depends only on state and count, never on tvalid.
  always_comb begin
    s_axis_tready = 1'b0;
    if ((state == S_PREAMBLE && cnt == 8'd7) || state == S_DATA || state == S_DRAIN)
      s_axis_tready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      byte_cnt   <= 11'd0;
      crc        <= 32'hFFFFFFFF;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (s_axis_tvalid) begin
            state      <= S_PREAMBLE;
            cnt        <= 8'd0;
            byte_cnt   <= 11'd0;
            crc        <= 32'hFFFFFFFF;
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
          end
        end

        S_PREAMBLE, S_DATA: begin
          gmii_tx_en <= 1'b1;
          if (state == S_PREAMBLE && cnt != 8'd7) begin
            cnt      <= cnt + 8'd1;
            gmii_txd <= (cnt == 8'd6) ? 8'hD5 : 8'h55;
          end else if (s_axis_tvalid) begin
            gmii_txd <= s_axis_tdata;
            crc      <= crc_next(crc, s_axis_tdata);
            byte_cnt <= cnt_inc;
            state    <= S_DATA;
            if (s_axis_tlast) begin
              cnt <= 8'd0;
`ifdef AXI_ETH_MAC_TX_PAD_EN
              if (cnt_inc < MIN_CNT)
                state <= S_PAD;
              else
`endif
                state <= S_FCS;
            end
          end else begin
            // Source ran dry mid-frame: poison the frame on the wire.
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            underrun   <= 1'b1;
            state      <= S_DRAIN;
          end
        end

`ifdef AXI_ETH_MAC_TX_PAD_EN
        S_PAD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h00;
          crc        <= crc_next(crc, 8'h00);
          byte_cnt   <= cnt_inc;
          if (cnt_inc >= MIN_CNT)
            state <= S_FCS;
        end
`endif

        S_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte;
          cnt        <= cnt + 8'd1;
          if (cnt == 8'd3) begin
            state      <= S_IFG;
            cnt        <= IFG_LOAD;
            crc        <= 32'hFFFFFFFF;
            frame_done <= 1'b1;
          end
        end

        S_DRAIN: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (s_axis_tvalid && s_axis_tlast) begin
            state <= S_IFG;
            cnt   <= IFG_LOAD;
          end
        end

        S_IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (cnt == 8'd0)
            state <= S_IDLE;
          else
            cnt <= cnt - 8'd1;
        end

        default: begin
          state      <= S_IDLE;
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
        end
      endcase
    end
  end

endmodule
